// File: rtl/pool_module.sv
// pool_module: 2x2 stride-2 max-pooling of four 4x4 feature maps.
// It reads each map from the scratchpad region (z = 1) one word per cycle, in
// window order, and writes 16 pooled words to output memory.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     one-cycle run request, sampled only in IDLE
//   busy      high from the first read cycle through the last write cycle
//   done      one-cycle pulse after the last write
//   sp_addr   scratchpad read address {1, y[3:0], x[3:0]}
//   sp_data   scratchpad read data, one cycle after sp_addr
//   out_addr  output memory write address
//   out_data  pooled value
//   out_we    write strobe, one cycle per pooled word
module pool_module #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_K    = 4,
  parameter int unsigned OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [8:0]        sp_addr,
  input  logic [DATA_W-1:0] sp_data,
  output logic [9:0]        out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  localparam logic [1:0] KLast = 2'(NUM_K - 1);

  state_e state_q, state_d;

  // Read-side counters, nesting elem -> px -> py -> k.
  logic [1:0] elem_q, elem_d;
  logic       px_q, px_d;
  logic       py_q, py_d;
  logic [1:0] k_q, k_d;

  // Counter copy delayed one cycle so it lines up with sp_data.
  logic       vld_q;
  logic [1:0] elem_p_q;
  logic       px_p_q, py_p_q;
  logic [1:0] k_p_q;

  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [9:0]        out_addr_q, out_addr_d;
  logic              out_we_q, out_we_d;
  logic [DATA_W-1:0] cand;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    px_d    = px_q;
    py_d    = py_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRead;
      end
      StRead: begin
        elem_d = elem_q + 2'd1;
        if (elem_q == 2'd3) begin
          px_d = ~px_q;
          if (px_q) begin
            py_d = ~py_q;
            if (py_q) begin
              if (k_q == KLast) begin
                k_d     = 2'd0;
                state_d = StDrain;
              end else begin
                k_d = k_q + 2'd1;
              end
            end
          end
        end
      end
      StDrain: begin
        // The only write seen in DRAIN is the final one.
        if (out_we_q) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cand       = (sp_data > max_q) ? sp_data : max_q;
    max_d      = max_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    out_we_d   = 1'b0;
    if (vld_q) begin
      max_d = (elem_p_q == 2'd0) ? sp_data : cand;
      if (elem_p_q == 2'd3) begin
        out_data_d = cand;
        out_we_d   = 1'b1;
        out_addr_d = 10'(OUT_BASE) + {6'd0, k_p_q, py_p_q, px_p_q};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      elem_q     <= 2'd0;
      px_q       <= 1'b0;
      py_q       <= 1'b0;
      k_q        <= 2'd0;
      vld_q      <= 1'b0;
      elem_p_q   <= 2'd0;
      px_p_q     <= 1'b0;
      py_p_q     <= 1'b0;
      k_p_q      <= 2'd0;
      max_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      out_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      px_q       <= px_d;
      py_q       <= py_d;
      k_q        <= k_d;
      vld_q      <= (state_q == StRead);
      elem_p_q   <= elem_q;
      px_p_q     <= px_q;
      py_p_q     <= py_q;
      k_p_q      <= k_q;
      max_q      <= max_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      out_we_q   <= out_we_d;
    end
  end

  // y = 4k + 2py + dy, x = 2px + dx (zero-extended to 4 bits).
  assign sp_addr  = (state_q == StRead) ?
                    {1'b1, k_q, py_q, elem_q[1], 2'b00, px_q, elem_q[0]} : 9'd0;
  assign busy     = (state_q == StRead) || (state_q == StDrain);
  assign done     = (state_q == StFin);
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign out_we   = out_we_q;

endmodule

// File: tb/tb_pool_module.sv
module tb_pool_module;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, out_we;
  logic [8:0]  sp_addr;
  logic [15:0] sp_data;
  logic [9:0]  out_addr;
  logic [15:0] out_data;

  logic [15:0] mem [512];
  logic [15:0] exp_data [16];
  int n_vec = 0;
  int n_err = 0;

  localparam logic [15:0] RampExp [16] = '{16'd17, 16'd19, 16'd49, 16'd51, 16'd81, 16'd83,
                                          16'd113, 16'd115, 16'd145, 16'd147, 16'd177,
                                          16'd179, 16'd209, 16'd211, 16'd241, 16'd243};

  pool_module #(.DATA_W(16), .NUM_K(4), .OUT_BASE(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .sp_addr  (sp_addr),
    .sp_data  (sp_data),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_we   (out_we)
  );

  always #5 clk = ~clk;

  // Registered scratchpad read: data one cycle after address.
  always @(posedge clk) sp_data <= mem[sp_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sp_addr"}, 32'(sp_addr), 0);
    chk({tag, "_out_addr"}, 32'(out_addr), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_out_we"}, 32'(out_we), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 512; i++) mem[i] = 16'hDEAD;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) mem[256 + 16 * y + x] = 16'(16 * y + x);
    for (int i = 0; i < 16; i++) exp_data[i] = RampExp[i];
  endtask

  // One run: start sampled at E0, then cycles 1..n observed at the falling edge.
  task automatic run(input string tag, input int pulse_at, input int abort_at,
                     input bit chk_addr);
    int wcnt;
    int w, e, y, x;
    logic [8:0] ea;
    wcnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        chk_reset_outputs({tag, "_midreset"});
        return;
      end
      chk({tag, "_busy"}, 32'(busy), 32'(c <= 66));
      chk({tag, "_done"}, 32'(done), 32'(c == 67));
      if (chk_addr && c <= 64) begin
        w  = (c - 1) / 4;
        e  = (c - 1) % 4;
        y  = 4 * (w / 4) + 2 * ((w / 2) % 2) + e / 2;
        x  = 2 * (w % 2) + e % 2;
        ea = {1'b1, 4'(y), 4'(x)};
        chk({tag, "_sp_addr"}, 32'(sp_addr), 32'(ea));
        chk({tag, "_sp_z"}, 32'(sp_addr[8]), 1);
      end
      if (out_we) begin
        if (wcnt < 16) begin
          chk({tag, "_wr_cyc"}, c, 4 * wcnt + 6);
          chk({tag, "_wr_addr"}, 32'(out_addr), wcnt);
          chk({tag, "_wr_data"}, 32'(out_data), 32'(exp_data[wcnt]));
        end
        wcnt++;
      end
    end
    chk({tag, "_wr_count"}, wcnt, 16);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    fill_ramp();
    #1;
    chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Ramp fill with per-cycle address check.
    run("ramp", 0, 0, 1'b1);

    // One 16'hFFFF per window, walking through all four element positions.
    for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    for (int w = 0; w < 16; w++) begin
      int e;
      int y, x;
      e = w % 4;
      y = 4 * (w / 4) + 2 * ((w / 2) % 2) + e / 2;
      x = 2 * (w % 2) + e % 2;
      mem[256 + 16 * y + x] = 16'hFFFF;
      exp_data[w] = 16'hFFFF;
    end
    run("sweep", 0, 0, 1'b0);

    // All-zero maps; out_data previously held FFFF.
    for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    for (int i = 0; i < 16; i++) exp_data[i] = 16'h0;
    run("zero", 0, 0, 1'b0);

    // Extra start at cycle 20 is ignored; back-to-back run starts at cycle 68.
    fill_ramp();
    run("busy_start", 20, 0, 1'b0);
    run("second", 0, 0, 1'b0);

    // Reset mid-run at cycle 30, then quiet for 100 cycles, then a clean rerun.
    run("abort", 0, 30, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    begin
      int we_seen;
      int busy_seen;
      we_seen = 0;
      busy_seen = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (out_we) we_seen++;
        if (busy) busy_seen++;
      end
      chk("post_reset_we", we_seen, 0);
      chk("post_reset_busy", busy_seen, 0);
    end
    run("rerun", 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pool_module.md
# pool_module

Downstream of the convolution quadrant stage: once a quadrant's 4x4 ReLU'd feature maps (one per kernel, four kernels) are complete in the scratchpad region (z = 1) of the data memory, this block performs 2x2 stride-2 max-pooling on each map. It writes the resulting 2x2 pooled values per kernel, 16 words total, to the output memory. The controller starts it with a one-cycle pulse and waits for `done`.

## Interface
- `DATA_W`, 16, data word width for scratchpad and output.
- `NUM_K`, 4, number of kernel feature maps (fixed layout: map k occupies scratchpad rows 4k..4k+3).
- `OUT_BASE`, 0, base word address in output memory.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse from the controller; sampled only in IDLE.
- `busy` output 1: high from the first read cycle through the last write cycle.
- `done` output 1: one-cycle pulse after the last write.
- `sp_addr` output 9: scratchpad read address {z=1, y[3:0], x[3:0]}.
- `sp_data` input DATA_W: read data, valid one cycle after `sp_addr`.
- `out_addr` output 10: output memory write address.
- `out_data` output DATA_W: pooled value.
- `out_we` output 1: write enable, one cycle per pooled word.

## Operation
- FSM states: IDLE, READ, DRAIN, FIN.
  - IDLE: `start`=1 goes to READ. Otherwise stays in IDLE.
  - READ: issues one address per cycle for 64 cycles, then goes to DRAIN.
  - DRAIN: lasts until the final write has been issued, then goes to FIN.
  - FIN: pulses `done` for one cycle, then returns to IDLE.
- Read order: kernel k = 0..3; within each kernel, window (py, px) in raster order, px fastest.
- Within each window, elements are read as (dy, dx) = (0,0), (0,1), (1,0), (1,1).
- `sp_addr` = {1'b1, 4k+2py+dy, 2px+dx}, with x zero-extended to 4 bits.
- Counters: 2-bit element, 1-bit px, 1-bit py, 2-bit k. They nest as element → px → py → k. Each wraps to 0 on carry.
- Running max register:
  - On the first element of a window, it loads `sp_data` unconditionally.
  - On elements 2–4, it takes the unsigned max of itself and `sp_data`.
  - A tie keeps the current value (no observable difference).
- When the 4th element's data arrives, max(reg, `sp_data`) is registered into `out_data`. In the same edge, `out_we` is set to 1 for exactly one cycle.
- `out_addr` = OUT_BASE + 4k + 2py + px, computed from a delayed copy of the counters that is aligned to the data.
- Output of the write port is 16 words, at OUT_BASE+0 .. OUT_BASE+15.
- `start` asserted while not in IDLE is ignored. The run is never restarted or extended.
- Scratchpad contents are not checked. Any 16-bit value is compared as unsigned; 16'hFFFF is a valid maximum.

## Timing
- Let E0 be the clock edge at which `start`=1 is sampled in IDLE.
- Read window w = 0..15, element e = 0..3:
  - `sp_addr` is valid in cycle 4w+e+1 after E0.
  - `sp_data` is valid in cycle 4w+e+2.
- Write for window w: `out_we`=1 in cycle 4w+6.
  - First write: cycle 6. Last write: cycle 66.
  - Writes are spaced exactly 4 cycles apart.
- `busy`=1 in cycles 1..66 inclusive. `done`=1 in cycle 67 only. The block is back in IDLE at cycle 68 and can accept a new `start` then.
- Total latency from `start` to `done` is 67 cycles, fixed and data-independent.
- Reset values, asynchronous on `reset`=0:
  - State = IDLE and all counters = 0.
  - Max register = 0.
  - `sp_addr` = 0, `out_addr` = 0, `out_data` = 0.
  - `out_we` = 0, `busy` = 0, `done` = 0.
- Reset mid-run: outputs go to their reset values immediately (combinationally via async clear).
  - No further writes occur after release.
  - A new `start` is required to begin a fresh run.
- Outside READ, `sp_addr` is held at 0.
- Outside write cycles, `out_data` holds its last value while `out_we` is 0.

## Test plan
- Ramp fill: scratchpad (z=1, y, x) = 16·y + x. Start. The 16 writes in order are {17,19,49,51, 81,83,113,115, 145,147,177,179, 209,211,241,243} at addresses OUT_BASE+0..15. `done` occurs at cycle 67.
- Position sweep: each window holds zeros plus one 16'hFFFF, placed at element e = w mod 4. Every output equals 16'hFFFF, which proves all four positions are compared.
- All-zero maps: 16 writes of 0, with `out_we` high exactly 16 times, in cycles 6, 10, ..., 66.
- Start during busy: pulse `start` again at cycle 20. There is still exactly one `done` at cycle 67 and exactly 16 writes. Then start a second run at cycle 68; its `done` occurs at cycle 135.
- Reset mid-run: drop `reset` at cycle 30. All outputs go to 0 at once. Release the reset; with no `start`, no `out_we` occurs for 100 cycles. A following `start` reproduces the ramp result exactly.
- Address check: during the ramp run, compare `sp_addr` against the formula every cycle from 1 to 64, and confirm bit 8 = 1 throughout.
